// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared encodings for the ID/EX stage: forwarding-mux select codes and
// the hardwired-zero register number.
package id_ex_fwd_stage_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel_calc.sv
// Combinational forwarding-select calculation for one EX operand source.
// The youngest producer wins: the instruction now in EX beats the one now in EX/MEM.
module fwd_sel_calc
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_eff_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

    // ex_eff_write already excludes rd==0, so only the EX/MEM term needs the r0 guard.
    always_comb begin
        sel = FWD_IDEX;
        if (ex_eff_write && (ex_rd == src_addr)) begin
            sel = FWD_EXMEM;
        end else if (exmem_regwrite && (exmem_rd == src_addr) && (src_addr != ZERO_ADDR)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with registered forwarding selects, WB bypass of
// register-file reads and load-use stall detection.
module id_ex_fwd_stage
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_addr_o,
    output logic [REG_AW-1:0] ex_rt_addr_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

    logic              ex_eff_write;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    assign ex_eff_write = ex_regwrite_o && ex_valid_o && (ex_rd_o != ZERO_ADDR);

    assign stall_o = id_valid_i && ex_valid_o && ex_memread_o && (ex_rd_o != ZERO_ADDR) &&
                     ((ex_rd_o == id_rs_addr_i) || (ex_rd_o == id_rt_addr_i));

    // The register file is not write-first, so a same-cycle WB write is bypassed here.
    assign rs_data = (wb_regwrite_i && (wb_rd_i == id_rs_addr_i) && (id_rs_addr_i != ZERO_ADDR))
                     ? wb_data_i : id_rs_data_i;
    assign rt_data = (wb_regwrite_i && (wb_rd_i == id_rt_addr_i) && (id_rt_addr_i != ZERO_ADDR))
                     ? wb_data_i : id_rt_data_i;

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
        .src_addr       (id_rs_addr_i),
        .ex_rd          (ex_rd_o),
        .ex_eff_write   (ex_eff_write),
        .exmem_rd       (exmem_rd_i),
        .exmem_regwrite (exmem_regwrite_i),
        .sel            (sel_a)
    );

    fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
        .src_addr       (id_rt_addr_i),
        .ex_rd          (ex_rd_o),
        .ex_eff_write   (ex_eff_write),
        .exmem_rd       (exmem_rd_i),
        .exmem_regwrite (exmem_regwrite_i),
        .sel            (sel_b)
    );

    // Flush and stall both insert an all-zero bubble; the stalled instruction is re-presented by ID.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_rs_data_o  <= '0;
            ex_rt_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_rs_addr_o  <= '0;
            ex_rt_addr_o  <= '0;
            ex_rd_o       <= '0;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_ctrl_o     <= '0;
            fwd_a_sel_o   <= FWD_IDEX;
            fwd_b_sel_o   <= FWD_IDEX;
        end else if (flush_i || stall_o) begin
            ex_valid_o    <= 1'b0;
            ex_rs_data_o  <= '0;
            ex_rt_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_rs_addr_o  <= '0;
            ex_rt_addr_o  <= '0;
            ex_rd_o       <= '0;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_ctrl_o     <= '0;
            fwd_a_sel_o   <= FWD_IDEX;
            fwd_b_sel_o   <= FWD_IDEX;
        end else begin
            ex_valid_o    <= id_valid_i;
            ex_rs_data_o  <= rs_data;
            ex_rt_data_o  <= rt_data;
            ex_imm_o      <= id_imm_i;
            ex_rs_addr_o  <= id_rs_addr_i;
            ex_rt_addr_o  <= id_rt_addr_i;
            ex_rd_o       <= id_rd_addr_i;
            ex_regwrite_o <= id_regwrite_i;
            ex_memread_o  <= id_memread_i;
            ex_ctrl_o     <= id_ctrl_i;
            fwd_a_sel_o   <= sel_a;
            fwd_b_sel_o   <= sel_b;
        end
    end

endmodule
